// File: rtl/number_string_formatter.sv
// number_string_formatter
// Converts an unsigned binary value into DIGITS decimal character codes using
// a sequential double-dabble (shift-and-add-3) conversion, one bit per cycle.
//
// Ports:
//   clock     - system clock, all state on rising edge
//   reset_n   - asynchronous active-low reset
//   start     - conversion request, sampled only in IDLE
//   value     - binary input, captured when start is accepted
//   busy      - high during CONVERT and FORMAT
//   done      - one-cycle pulse when chars/overflow have been updated
//   overflow  - last captured value did not fit in DIGITS decimal digits
//   chars     - DIGITS character codes, slot 0 in the low CHAR_W bits
//
// Build option: LEADING_ZERO_BLANK_EN replaces leading zero digits (other than
// slot 0) with BLANK_CODE. Overflow output is always all nines.
//
// state   | meaning
// IDLE    | waiting for start
// CONVERT | one double-dabble step per cycle, VALUE_W steps
// FORMAT  | build character codes from the BCD accumulator
// DONE    | outputs updated, done pulse
module number_string_formatter #(
  parameter int VALUE_W    = 14,
  parameter int DIGITS     = 4,
  parameter int CHAR_W     = 6,
  parameter int ZERO_CODE  = 26,
  parameter int BLANK_CODE = 0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [VALUE_W-1:0]       value,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [DIGITS*CHAR_W-1:0] chars
);

  // floor(VALUE_W*log10(2))+1 decimal digits hold 2^VALUE_W-1. The accumulator
  // is never narrower than DIGITS so every slot has a nibble to read.
  localparam int BCD_D = (VALUE_W * 30103) / 100000 + 1;
  localparam int ACC_D = (BCD_D > DIGITS) ? BCD_D : DIGITS;
  localparam int ACC_W = ACC_D * 4;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  localparam logic [CHAR_W-1:0] ZERO_C  = CHAR_W'(ZERO_CODE);
  localparam logic [CHAR_W-1:0] NINE_C  = CHAR_W'(ZERO_CODE + 9);
  localparam logic [CHAR_W-1:0] BLANK_C = CHAR_W'(BLANK_CODE);
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [CHAR_W-1:0] RST_HI_C = BLANK_C;
`else
  localparam logic [CHAR_W-1:0] RST_HI_C = ZERO_C;
`endif

  typedef enum logic [1:0] {IDLE, CONVERT, FORMAT, DONE} state_t;

  state_t                     state_q, state_d;
  logic [VALUE_W-1:0]         val_q, val_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [DIGITS*CHAR_W-1:0]   chars_q, chars_d;
  logic                       ovf_q, ovf_d;

  logic [ACC_W-1:0]           adj;
  logic [DIGITS*CHAR_W-1:0]   fmt_chars;
  logic                       fmt_ovf;
  logic                       seen_nz;
  logic [3:0]                 dig;

  // Character formatting from the finished accumulator.
  always_comb begin
    fmt_ovf   = 1'b0;
    fmt_chars = '0;
    seen_nz   = 1'b0;
    dig       = 4'd0;
    for (int i = DIGITS; i < ACC_D; i++) begin
      if (acc_q[i*4 +: 4] != 4'd0) fmt_ovf = 1'b1;
    end
    // Walk from the top slot down so seen_nz marks the first significant digit.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig = acc_q[i*4 +: 4];
      if (dig != 4'd0 || i == 0) seen_nz = 1'b1;
      if (fmt_ovf) begin
        fmt_chars[i*CHAR_W +: CHAR_W] = NINE_C;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        fmt_chars[i*CHAR_W +: CHAR_W] = seen_nz ? ZERO_C + CHAR_W'(dig) : BLANK_C;
`else
        fmt_chars[i*CHAR_W +: CHAR_W] = ZERO_C + CHAR_W'(dig);
`endif
      end
    end
  end

  // Add-3 correction applied before each shift.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < ACC_D; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    chars_d = chars_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          val_d   = value;
          acc_d   = '0;
          cnt_d   = CNT_W'(VALUE_W);
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        {acc_d, val_d} = {adj[ACC_W-2:0], val_q, 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FORMAT;
      end
      FORMAT: begin
        // Output registers load on the edge into DONE, so they are valid with done.
        chars_d = fmt_chars;
        ovf_d   = fmt_ovf;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      val_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        chars_q[i*CHAR_W +: CHAR_W] <= (i == 0) ? ZERO_C : RST_HI_C;
      end
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      chars_q <= chars_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == CONVERT) || (state_q == FORMAT);
  assign done     = (state_q == DONE);
  assign overflow = ovf_q;
  assign chars    = chars_q;

endmodule
